// File: rtl/sram_like_arb_pkg.sv
// sram_like_arb_pkg: shared state encoding, requester IDs and round-robin pick.
package sram_like_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    typedef enum logic {INST = 1'b0, DATA = 1'b1} req_id_t;

    // Under contention the side not granted last wins; otherwise whoever asks.
    function automatic req_id_t pick(input logic inst_req, input logic data_req, input req_id_t last);
        return (inst_req && data_req) ? ((last == INST) ? DATA : INST) : (data_req ? DATA : INST);
    endfunction

endpackage

// File: rtl/sram_like_arb.sv
// sram_like_arb: round-robin merge of instruction and data sram-like masters
// onto one bus bridge port, with at most one transfer outstanding.
module sram_like_arb
    import sram_like_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        addr_ok,
    input  logic        data_ok
);

    state_t  state, state_n;
    req_id_t owner, last_grant, sel, cur;
    logic    sel_req, src, hs, done;

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    always_comb begin
        sel          = pick(inst_req, data_req, last_grant);
        sel_req      = (sel == DATA) ? data_req : inst_req;
        cur          = (state == BUSY) ? owner : sel;
        src          = (state == BUSY) || sel_req;
        req          = !rst && (state == IDLE) && sel_req;
        hs           = req && addr_ok;
        // data_ok only counts for an owned transfer or a same-cycle handshake
        done         = !rst && ((state == BUSY) || hs) && data_ok;
        wr           = src && ((cur == DATA) ? data_wr : inst_wr);
        size         = src ? ((cur == DATA) ? data_size : inst_size) : 2'b00;
        addr         = src ? ((cur == DATA) ? data_addr : inst_addr) : 32'h0;
        wdata        = src ? ((cur == DATA) ? data_wdata : inst_wdata) : 32'h0;
        inst_addr_ok = hs && (sel == INST);
        data_addr_ok = hs && (sel == DATA);
        inst_data_ok = done && (cur == INST);
        data_data_ok = done && (cur == DATA);
        state_n      = (state == IDLE && hs && !data_ok) ? BUSY :
                       (state == BUSY && data_ok) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= INST;
            last_grant <= INST;
        end else begin
            state <= state_n;
            if (hs) begin
                owner      <= sel;
                last_grant <= sel;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arb.sv
// tb_sram_like_arb: directed scenarios plus randomized traffic checked
// against a transaction-level model (pending queue + last winner).
module tb_sram_like_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        addr_ok, data_ok;

    int checks = 0;
    int failures = 0;

    int pend[$];
    int last_g = 0;

    always #5 clk = ~clk;

    sram_like_arb dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
    );

    wire [4:0]  flags  = {req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    wire [66:0] fields = {wr, size, addr, wdata};

    // 0 = instruction side, 1 = data side
    function automatic int winner();
        if (inst_req && data_req) return 1 - last_g;
        return data_req ? 1 : 0;
    endfunction

    function automatic logic [4:0] exp_flags();
        logic any, h, c;
        int w;
        if (rst) return 5'b0;
        if (pend.size() != 0)
            return {1'b0, 1'b0, pend[0] == 0 && data_ok, 1'b0, pend[0] == 1 && data_ok};
        any = inst_req || data_req;
        w = winner();
        h = any && addr_ok;
        c = h && data_ok;
        return {any, h && w == 0, c && w == 0, h && w == 1, c && w == 1};
    endfunction

    function automatic logic [66:0] exp_fields();
        int who;
        if (pend.size() != 0) who = pend[0];
        else if (inst_req || data_req) who = winner();
        else return 67'b0;
        return who == 1 ? {data_wr, data_size, data_addr, data_wdata}
                        : {inst_wr, inst_size, inst_addr, inst_wdata};
    endfunction

    task automatic model_update();
        int w;
        if (rst) begin
            pend.delete();
            last_g = 0;
        end else if (pend.size() != 0) begin
            if (data_ok) void'(pend.pop_front());
        end else if ((inst_req || data_req) && addr_ok) begin
            w = winner();
            last_g = w;
            if (!data_ok) pend.push_back(w);
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        addr_ok = 0; data_ok = 0; rdata = $urandom;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        for (int c = 0; c < 3; c++) begin
            #4;
            checks++;
            if (flags !== 5'b0) begin
                failures++;
                $display("FAIL reset_flags cyc=%0d got=%b exp=00000", c, flags);
            end
            tick();
        end
        rst = 0;
        idle_inputs();
        data_ok = 1;
        #4;
        checks++;
        if (flags !== 5'b0 || fields !== 67'b0) begin
            failures++;
            $display("FAIL post_reset_idle got flags=%b fields=%h exp 0", flags, fields);
        end
        tick();
        idle_inputs();
        inst_req = 1; data_req = 1; inst_addr = 32'h111; data_addr = 32'h222;
        #4;
        checks++;
        if (req !== 1'b1 || addr !== 32'h222) begin
            failures++;
            $display("FAIL reset_first_grant got req=%b addr=%h exp req=1 addr=00000222", req, addr);
        end
        tick();
    endtask

    task automatic test_single_read();
        logic [4:0] e;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            data_req = (c <= 2);
            data_addr = 32'h1000;
            addr_ok = (c == 2);
            data_ok = (c == 5);
            rdata = (c == 5) ? 32'hDEADBEEF : $urandom;
            e = (c < 2) ? 5'b10000 : (c == 2) ? 5'b10010 : (c == 5) ? 5'b00001 : 5'b00000;
            #4;
            checks++;
            if (flags !== e) begin
                failures++;
                $display("FAIL single_read_flags cyc=%0d got=%b exp=%b", c, flags, e);
            end
            if (c <= 2) begin
                checks++;
                if (addr !== 32'h1000) begin
                    failures++;
                    $display("FAIL single_read_addr cyc=%0d got=%h exp=00001000", c, addr);
                end
            end
            if (c == 5) begin
                checks++;
                if (data_rdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL single_read_rdata got=%h exp=deadbeef", data_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_contention();
        logic d;
        do_reset();
        inst_req = 1; data_req = 1;
        inst_addr = 32'hBFC0_0000; data_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            d = (k % 2 == 0);
            addr_ok = 1; data_ok = 0;
            #4;
            checks++;
            if (flags !== {1'b1, !d, 1'b0, d, 1'b0} || addr !== (d ? data_addr : inst_addr)) begin
                failures++;
                $display("FAIL contention_grant k=%0d got flags=%b addr=%h exp data_side=%0b", k, flags, addr, d);
            end
            tick();
            addr_ok = 0; data_ok = 1;
            #4;
            checks++;
            if (flags !== {1'b0, 1'b0, !d, 1'b0, d}) begin
                failures++;
                $display("FAIL contention_done k=%0d got=%b exp data_side=%0b", k, flags, d);
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        inst_req = 1; inst_addr = 32'hBFC0_0000; addr_ok = 1; data_ok = 1;
        #4;
        checks++;
        if (flags !== 5'b11100 || addr !== 32'hBFC0_0000) begin
            failures++;
            $display("FAIL same_cycle got flags=%b addr=%h exp 11100 bfc00000", flags, addr);
        end
        tick();
        inst_addr = 32'hBFC0_0004; data_ok = 0;
        #4;
        checks++;
        if (flags !== 5'b11000 || addr !== 32'hBFC0_0004) begin
            failures++;
            $display("FAIL same_cycle_next got flags=%b addr=%h exp 11000 bfc00004", flags, addr);
        end
        tick();
        inst_req = 0; addr_ok = 0; data_ok = 1;
        #4;
        checks++;
        if (flags !== 5'b00100) begin
            failures++;
            $display("FAIL same_cycle_finish got=%b exp=00100", flags);
        end
        tick();
    endtask

    task automatic test_write();
        logic [66:0] e;
        do_reset();
        inst_addr = $urandom; inst_wdata = $urandom; inst_wr = 1; inst_size = 2'b10;
        data_req = 1; data_wr = 1; data_size = 2'b00; data_addr = 32'h2003; data_wdata = 32'hAB;
        e = {1'b1, 2'b00, 32'h2003, 32'h0000_00AB};
        for (int c = 0; c < 5; c++) begin
            addr_ok = (c == 0);
            data_ok = (c == 4);
            #4;
            checks++;
            if (fields !== e || flags !== ((c == 0) ? 5'b10010 : (c == 4) ? 5'b00001 : 5'b00000)) begin
                failures++;
                $display("FAIL write cyc=%0d got fields=%h flags=%b exp fields=%h", c, fields, flags, e);
            end
            tick();
            data_req = 0;
        end
    endtask

    task automatic test_rst_busy();
        do_reset();
        data_req = 1; data_addr = 32'h3000; addr_ok = 1;
        #4;
        checks++;
        if (flags !== 5'b10010) begin
            failures++;
            $display("FAIL rst_busy_grant got=%b exp=10010", flags);
        end
        tick();
        data_req = 0; addr_ok = 0; rst = 1;
        tick();
        rst = 0; data_ok = 1;
        #4;
        checks++;
        if (flags !== 5'b0) begin
            failures++;
            $display("FAIL rst_busy_stray got=%b exp=00000", flags);
        end
        tick();
        data_ok = 0; inst_req = 1; data_req = 1; inst_addr = 32'h4000;
        #4;
        checks++;
        if (req !== 1'b1 || addr !== 32'h3000) begin
            failures++;
            $display("FAIL rst_busy_regrant got req=%b addr=%h exp req=1 addr=00003000", req, addr);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0]  ef;
        logic [66:0] ex;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!inst_req) inst_req = $urandom_range(0, 2) == 0;
            if (!data_req) data_req = $urandom_range(0, 2) == 0;
            inst_wr = $urandom; inst_size = $urandom; inst_addr = $urandom; inst_wdata = $urandom;
            data_wr = $urandom; data_size = $urandom; data_addr = $urandom; data_wdata = $urandom;
            addr_ok = $urandom_range(0, 1);
            data_ok = $urandom_range(0, 2) == 0;
            rdata = $urandom;
            #4;
            ef = exp_flags();
            ex = exp_fields();
            checks++;
            if (flags !== ef || (!rst && fields !== ex) || inst_rdata !== rdata || data_rdata !== rdata) begin
                failures++;
                $display("FAIL random cyc=%0d got flags=%b fields=%h exp flags=%b fields=%h", c, flags, fields, ef, ex);
            end
            if (ef[3]) inst_req = 0;
            if (ef[1]) data_req = 0;
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        #1;
        test_reset();
        test_single_read();
        test_contention();
        test_same_cycle();
        test_write();
        test_rst_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_like_arb.md
SRAM_LIKE_ARB -- requirements
Module: sram_like_arb

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have inputs inst_req(1), inst_wr(1), inst_size(2), inst_addr(32), inst_wdata(32): instruction-side sram-like request.
REQ-004 SHALL have outputs inst_rdata(32), inst_addr_ok(1), inst_data_ok(1): instruction-side response.
REQ-005 SHALL have inputs data_req(1), data_wr(1), data_size(2), data_addr(32), data_wdata(32): data-side sram-like request.
REQ-006 SHALL have outputs data_rdata(32), data_addr_ok(1), data_data_ok(1): data-side response.
REQ-007 SHALL have outputs req(1), wr(1), size(2), addr(32), wdata(32): merged sram-like request to the bus bridge.
REQ-008 SHALL have inputs rdata(32), addr_ok(1), data_ok(1): bus bridge response.

Function
REQ-009 SHALL implement a 2-state FSM: IDLE (no outstanding transfer), BUSY (one transfer accepted, awaiting data_ok).
REQ-010 In IDLE, SHALL select one requester combinationally: only one requesting -> that one; both requesting -> the one NOT granted last (round-robin via a 1-bit last_grant register).
REQ-011 In IDLE, req SHALL equal the selected requester's req, and wr/size/addr/wdata SHALL be that requester's fields. With no requester, req=0 and the other merged fields SHALL be 0.
REQ-012 addr_ok SHALL be routed only to the selected requester in IDLE; the non-selected requester's addr_ok SHALL be 0.
REQ-013 IDLE and req&addr_ok&~data_ok SHALL go to BUSY, latch owner = selected requester, and set last_grant = selected requester.
REQ-014 IDLE and req&addr_ok&data_ok in the same cycle SHALL complete immediately: data_ok routed to the selected requester, last_grant updated, and the FSM SHALL stay in IDLE.
REQ-015 In BUSY, req SHALL be 0, both *_addr_ok SHALL be 0, and the merged fields SHALL hold the owner's current inputs.
REQ-016 In BUSY, data_ok SHALL be routed to owner's *_data_ok only, with a 0-cycle latency (combinational); on data_ok the FSM SHALL return to IDLE next cycle.
REQ-017 rdata SHALL be fanned out unmodified to inst_rdata and data_rdata; only *_data_ok qualifies it.
REQ-018 data_ok arriving in IDLE without a same-cycle addr_ok handshake SHALL be ignored: no *_data_ok asserted, no state change.
REQ-019 At most one transfer SHALL be outstanding; a requester held off SHALL keep req high and is served no later than the second IDLE grant (starvation bound).
REQ-020 A new grant SHALL be possible in the cycle immediately after BUSY exits (1 idle-bus cycle between back-to-back transfers).

Reset
REQ-021 On rst, SHALL set state=IDLE, owner=INST, last_grant=INST, so data side wins the first contention.
REQ-022 During and after rst, req, all *_addr_ok and all *_data_ok SHALL be 0 until a requester asserts req with rst low.
REQ-023 rst during BUSY SHALL abandon the outstanding transfer; a late data_ok after reset SHALL be ignored per REQ-018.

Structure
REQ-024 Shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and requester IDs (INST=0, DATA=1).
REQ-025 SHALL be a single module; no sub-module is required; the round-robin pick SHALL be a local function/combinational block.

Verification
REQ-026 Single data read: data_req=1, addr=0x1000; addr_ok cycle 2, data_ok cycle 5 with rdata=0xDEADBEEF -> data_addr_ok pulse cycle 2, data_data_ok cycle 5 with data_rdata=0xDEADBEEF, inst_* ok stays 0.
REQ-027 Contention after reset: both req high at cycle 0 -> data granted first (addr=data_addr); after its data_ok, inst granted next; then alternate for 4 transfers (D,I,D,I).
REQ-028 Same-cycle addr_ok&data_ok on inst fetch 0xBFC00000 -> inst_addr_ok and inst_data_ok in one cycle, FSM stays IDLE, next request granted in the following cycle.
REQ-029 Data write wr=1, size=2'b00, addr=0x2003, wdata=0x000000AB -> merged wr=1, size=0, addr=0x2003, wdata=0xAB unchanged; req=0 throughout BUSY.
REQ-030 rst asserted in BUSY, then stray data_ok -> no *_data_ok asserted, state IDLE, next contention grants data first.
